// File: rtl/multi_port_axi_bridge_pkg.sv
// Shared types and helpers for the multi-port AXI3 bridge.
// Port states, AXI constants and size/strobe conversion.
package axi_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PEND = 2'd1,
    WR_PEND = 2'd2
  } PortState;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_LEN_SINGLE = 4'h0;

  function automatic logic [3:0] size_to_strobe(
    input logic [1:0] size,
    input logic [1:0] a
  );
    case (size)
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_to_axsize(
    input logic [1:0] size
  );
    return (size == 2'd3) ? 3'd2 : {1'b0, size};
  endfunction

endpackage

// File: rtl/multi_port_axi_bridge_if.sv
// AXI3 single-beat master bus used by the bridge.
// The master modport is the bridge side, slave is the memory side.
interface multi_port_axi_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [3:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [1:0]            arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [3:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic [1:0]            awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [ID_WIDTH-1:0]   wid;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/multi_port_axi_bridge_rr_arbiter.sv
// Round-robin arbiter: pointer holds highest priority,
// moves to granted+1 whenever advance is high.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] request,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   sum;
  logic [PW:0]   nxt;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    sum   = '0;
    nxt   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && request[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        nxt        = sum + (PW+1)'(1);
        if (nxt >= (PW+1)'(N)) nxt = '0;
        if (advance) ptr_d = nxt[PW-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/multi_port_axi_bridge.sv
// SRAM-like requester ports bridged onto one single-beat AXI3 master.
// One outstanding transaction per port; AXI ID is the port index.
module multi_port_axi_bridge
  import axi_bridge_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            wr,
  input  logic [2*NUM_PORTS-1:0]          size,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0] addr,
  input  logic [32*NUM_PORTS-1:0]         wdata,
  output logic [32*NUM_PORTS-1:0]         rdata,
  output logic [NUM_PORTS-1:0]            addr_ok,
  output logic [NUM_PORTS-1:0]            data_ok,
  multi_port_axi_bridge_if.master         axi
);

  localparam int N  = NUM_PORTS;
  localparam int AW = ADDR_WIDTH;
  localparam int WW = ADDR_WIDTH - 2;

  PortState        state_q [N];
  PortState        state_d [N];
  logic [WW-1:0]   paddr_q [N];
  logic [WW-1:0]   paddr_d [N];

  logic [N-1:0]    haz_rd, haz_wr;
  logic [N-1:0]    rd_cand, wr_cand;
  logic [N-1:0]    rd_gnt, wr_gnt;
  logic [N-1:0]    data_ok_q, data_ok_d;
  logic [32*N-1:0] rdata_q, rdata_d;

  logic            arvalid_q, arvalid_d;
  logic [ID_WIDTH-1:0] arid_q, arid_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [2:0]      arsize_q, arsize_d;

  logic            awvalid_q, awvalid_d;
  logic [ID_WIDTH-1:0] awid_q, awid_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [2:0]      awsize_q, awsize_d;

  logic            wvalid_q, wvalid_d;
  logic [ID_WIDTH-1:0] wid_q, wid_d;
  logic [31:0]     wdat_q, wdat_d;
  logic [3:0]      wstrb_q, wstrb_d;

  logic            unused;
  assign unused = ^{axi.rresp, axi.rlast, axi.bresp};

  // Same-word hazard against any port pending in the opposite direction
  always_comb begin
    haz_rd  = '0;
    haz_wr  = '0;
    rd_cand = '0;
    wr_cand = '0;
    for (int p = 0; p < N; p++) begin
      for (int q = 0; q < N; q++) begin
        if (paddr_q[q] == addr[p*AW+2 +: WW]) begin
          if (state_q[q] == WR_PEND) haz_rd[p] = 1'b1;
          if (state_q[q] == RD_PEND) haz_wr[p] = 1'b1;
        end
      end
      if (!reset && state_q[p] == IDLE && req[p]) begin
        rd_cand[p] = !wr[p] && !haz_rd[p] && !arvalid_q;
        wr_cand[p] = wr[p] && !haz_wr[p] &&
                     !awvalid_q && !wvalid_q;
      end
    end
  end

  rr_arbiter #(.N(N)) u_rd_arb (
    .clock   (clock),
    .reset   (reset),
    .request (rd_cand),
    .advance (|rd_gnt),
    .grant   (rd_gnt)
  );

  rr_arbiter #(.N(N)) u_wr_arb (
    .clock   (clock),
    .reset   (reset),
    .request (wr_cand),
    .advance (|wr_gnt),
    .grant   (wr_gnt)
  );

  assign addr_ok = rd_gnt | wr_gnt;

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    rdata_d   = rdata_q;
    data_ok_d = '0;
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    awvalid_d = awvalid_q;
    awid_d    = awid_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wvalid_d  = wvalid_q;
    wid_d     = wid_q;
    wdat_d    = wdat_q;
    wstrb_d   = wstrb_q;

    if (arvalid_q && axi.arready) arvalid_d = 1'b0;
    if (awvalid_q && axi.awready) awvalid_d = 1'b0;
    if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;

    for (int p = 0; p < N; p++) begin
      if (rd_gnt[p]) begin
        arvalid_d  = 1'b1;
        arid_d     = ID_WIDTH'(p);
        araddr_d   = addr[p*AW +: AW];
        arsize_d   = size_to_axsize(size[2*p +: 2]);
        paddr_d[p] = addr[p*AW+2 +: WW];
        state_d[p] = RD_PEND;
      end
      if (wr_gnt[p]) begin
        awvalid_d  = 1'b1;
        wvalid_d   = 1'b1;
        awid_d     = ID_WIDTH'(p);
        wid_d      = ID_WIDTH'(p);
        awaddr_d   = addr[p*AW +: AW];
        awsize_d   = size_to_axsize(size[2*p +: 2]);
        wdat_d     = wdata[32*p +: 32];
        wstrb_d    = size_to_strobe(size[2*p +: 2],
                                    addr[p*AW +: 2]);
        paddr_d[p] = addr[p*AW+2 +: WW];
        state_d[p] = WR_PEND;
      end
      // Responses to ports not waiting for them fall through here
      if (axi.rvalid && axi.rid == ID_WIDTH'(p) &&
          state_q[p] == RD_PEND) begin
        rdata_d[32*p +: 32] = axi.rdata;
        data_ok_d[p]        = 1'b1;
        state_d[p]          = IDLE;
      end
      if (axi.bvalid && axi.bid == ID_WIDTH'(p) &&
          state_q[p] == WR_PEND) begin
        data_ok_d[p] = 1'b1;
        state_d[p]   = IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < N; p++) begin
        state_q[p] <= IDLE;
        paddr_q[p] <= '0;
      end
      rdata_q   <= '0;
      data_ok_q <= '0;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      awvalid_q <= 1'b0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wvalid_q  <= 1'b0;
      wid_q     <= '0;
      wdat_q    <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      rdata_q   <= rdata_d;
      data_ok_q <= data_ok_d;
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      awvalid_q <= awvalid_d;
      awid_q    <= awid_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wvalid_q  <= wvalid_d;
      wid_q     <= wid_d;
      wdat_q    <= wdat_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign rdata       = rdata_q;
  assign data_ok     = data_ok_q;

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = AXI_LEN_SINGLE;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = 1'b1;

  assign axi.awid    = awid_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = AXI_LEN_SINGLE;
  assign axi.awsize  = awsize_q;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = awvalid_q;

  assign axi.wid     = wid_q;
  assign axi.wdata   = wdat_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = 1'b1;

endmodule
